spi_flash_reader: RTL and testbench

- Single-bit SPI master that issues the standard flash READ command and streams the returned bytes out over a valid/ready interface.
- It is the initiator end of the flash bus served by the spiflash model used in our Caravel-level benches. It lets user-project logic (e.g. AES key/plaintext fetch) pull data straight from flash.
- It sits in the user project, behind a small CSR front-end that supplies start/addr/len.

---
 rtl/spi_flash_reader_if.sv | 27 ++
 rtl/spi_flash_reader.sv | 158 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_if.sv
// rtl/spi_flash_reader_if.sv - Control, byte-stream and flash-pin bundle for spi_flash_reader
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
);
  logic             start_i;
  logic [23:0]      addr_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o;
  logic             done_o;
  logic [7:0]       data_o;
  logic             data_valid_o;
  logic             data_ready_i;
  logic             flash_csb_o;
  logic             flash_clk_o;
  logic             flash_io0_o;
  logic             flash_io1_i;

  modport master (
    input  start_i, addr_i, len_i, data_ready_i, flash_io1_i,
    output busy_o, done_o, data_o, data_valid_o, flash_csb_o, flash_clk_o, flash_io0_o
  );

  modport slave (
    output start_i, addr_i, len_i, data_ready_i, flash_io1_i,
    input  busy_o, done_o, data_o, data_valid_o, flash_csb_o, flash_clk_o, flash_io0_o
  );
endinterface

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI mode-0 flash READ master streaming bytes over valid/ready
// `SPI_FLASH_FAST_READ_EN switches to FAST READ (0Bh) with 8 dummy clocks before data.
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input logic                wb_clk_i,
  input logic                wb_rst_i,
  spi_flash_reader_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, DONE} state_t;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD   = 8'h0B;
  localparam state_t     AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0] READ_CMD   = 8'h03;
  localparam state_t     AFTER_ADDR = DATA;
`endif

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [30:0]      tx_sr;
  logic [6:0]       rx_sr;
  logic [LEN_W-1:0] bytes_left;
  logic             sck;
  logic             csb;
  logic             mosi;
  logic             busy;
  logic             done;
  logic             valid;
  logic [7:0]       data;

  logic half_done;
  logic byte_edge;
  logic consume;
  logic stall;

  assign half_done = (div_cnt == DIV_LAST);
  assign byte_edge = (state == DATA) && (bit_cnt[2:0] == 3'd7);
  assign consume   = valid && bus.data_ready_i;
  // The 8th rising edge is withheld while an unconsumed byte still sits in data_o.
  assign stall     = byte_edge && !sck && valid && !bus.data_ready_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bytes_left <= '0;
      sck        <= 1'b0;
      csb        <= 1'b1;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      data       <= '0;
    end else begin
      done <= 1'b0;
      if (consume) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i != '0) begin
              tx_sr      <= {READ_CMD[6:0], bus.addr_i};
              mosi       <= READ_CMD[7];
              bytes_left <= bus.len_i;
              bit_cnt    <= '0;
              div_cnt    <= '0;
              csb        <= 1'b0;
              busy       <= 1'b1;
              state      <= CS_SETUP;
            end else begin
              done <= 1'b1;
            end
          end
        end

        CS_SETUP: begin
          if (half_done) begin
            div_cnt <= '0;
            state   <= CMD;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        CS_HOLD: begin
          if (half_done) begin
            div_cnt <= '0;
            csb     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DONE: state <= IDLE;

        default: begin
          if (stall) begin
            div_cnt <= '0;
          end else if (!half_done) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else if (!sck) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            if (state == DATA) begin
              rx_sr <= {rx_sr[5:0], bus.flash_io1_i};
              if (bit_cnt[2:0] == 3'd7) begin
                data       <= {rx_sr, bus.flash_io1_i};
                valid      <= 1'b1;
                bytes_left <= bytes_left - LEN_W'(1);
              end
            end
          end else begin
            // Falling edge: advance MOSI; the zero fill drives 0 once the address is out.
            div_cnt <= '0;
            sck     <= 1'b0;
            mosi    <= tx_sr[30];
            tx_sr   <= {tx_sr[29:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (state == CMD && bit_cnt == 5'd7) begin
              state <= ADDR;
            end else if (state == ADDR && bit_cnt == 5'd31) begin
              bit_cnt <= '0;
              state   <= AFTER_ADDR;
            end else if (state == DUMMY && bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else if (byte_edge && bytes_left == '0) begin
              state <= CS_HOLD;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.data_o       = data;
  assign bus.data_valid_o = valid;
  assign bus.flash_csb_o  = csb;
  assign bus.flash_clk_o  = sck;
  assign bus.flash_io0_o  = mosi;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - Directed self-checking bench for spi_flash_reader with a flash byte model
`timescale 1ns/1ps
module tb_spi_flash_reader;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 16;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD  = 8'h0B;
  localparam int         HDR_BITS = 40;
  localparam int         T_ONE    = 196;
`else
  localparam logic [7:0] EXP_CMD  = 8'h03;
  localparam int         HDR_BITS = 32;
  localparam int         T_ONE    = 164;
`endif

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;

  spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .bus     (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] exp_q [$];
  logic [7:0] rx_log [$];
  logic [7:0] exp_b;
  int         csb_low = 0;
  int         done_cnt = 0;
  bit         busy_seen = 0;
  bit         valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Flash: captures cmd+addr on SCK rise, shifts mem[addr..] out on SCK fall.
  int          fl_bits = 0;
  int          fl_k;
  logic [31:0] fl_hdr = '0;
  logic [7:0]  fl_byte;

  always @(posedge bus.flash_clk_o or posedge bus.flash_csb_o) begin
    if (bus.flash_csb_o) begin
      fl_bits = 0;
    end else begin
      if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], bus.flash_io0_o};
      fl_bits = fl_bits + 1;
    end
  end

  always @(negedge bus.flash_clk_o) begin
    if (!bus.flash_csb_o && fl_bits >= HDR_BITS) begin
      fl_k    = fl_bits - HDR_BITS;
      fl_byte = mem[10'(fl_hdr[9:0] + 10'(fl_k / 8))];
      bus.flash_io1_i = fl_byte[7 - (fl_k % 8)];
    end
  end

  always @(negedge wb_clk_i) begin
    if (bus.flash_csb_o === 1'b0) csb_low++;
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.busy_o === 1'b1) busy_seen = 1;
    if (bus.data_valid_o === 1'b1) valid_seen = 1;
  end

  // Every accepted byte must be the next one the flash contents predict.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && bus.data_valid_o === 1'b1 && bus.data_ready_i === 1'b1) begin
      rx_log.push_back(bus.data_o);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h, want no byte", bus.data_o);
      end else begin
        exp_b = exp_q.pop_front();
        check("stream_byte", {24'h0, bus.data_o}, {24'h0, exp_b});
      end
    end
  end

  task automatic clear_mon();
    csb_low    = 0;
    done_cnt   = 0;
    busy_seen  = 0;
    valid_seen = 0;
    rx_log.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [LEN_W-1:0] n, input bit expect_bytes);
    if (expect_bytes)
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[10'(a + 24'(i))]);
    @(posedge wb_clk_i); #1;
    bus.start_i = 1'b1;
    bus.addr_i  = a;
    bus.len_i   = n;
    @(posedge wb_clk_i); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (bus.done_o !== 1'b1 && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    check(name, {31'h0, bus.done_o === 1'b1}, 32'h1);
  endtask

  initial begin
    int sck_hi;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 7) + 8'h31);
    mem[0]   = 8'hDE;
    mem[1]   = 8'hAD;
    mem[2]   = 8'hBE;
    mem[3]   = 8'hEF;
    mem[256] = 8'h11;
    mem[257] = 8'h22;
    bus.start_i      = 1'b0;
    bus.addr_i       = '0;
    bus.len_i        = '0;
    bus.data_ready_i = 1'b1;
    bus.flash_io1_i  = 1'b0;

    wait_cycles(3);
    check("rst_busy",  {31'h0, bus.busy_o},       32'h0);
    check("rst_done",  {31'h0, bus.done_o},       32'h0);
    check("rst_data",  {24'h0, bus.data_o},       32'h0);
    check("rst_valid", {31'h0, bus.data_valid_o}, 32'h0);
    check("rst_csb",   {31'h0, bus.flash_csb_o},  32'h1);
    check("rst_sck",   {31'h0, bus.flash_clk_o},  32'h0);
    check("rst_mosi",  {31'h0, bus.flash_io0_o},  32'h0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    // Basic 4-byte read from address 0.
    clear_mon();
    pulse_start(24'h0, 4, 1);
    wait_done(3000, "basic_done");
    wait_cycles(4);
    check("basic_hdr",      fl_hdr, {EXP_CMD, 24'h000000});
    check("basic_csb_low",  csb_low, 2 * CLK_DIV + (HDR_BITS + 32) * 2 * CLK_DIV);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_csb_idle", {31'h0, bus.flash_csb_o}, 32'h1);
    check("basic_nbytes",   rx_log.size(), 4);
    check("basic_b0", {24'h0, rx_log[0]}, 32'hDE);
    check("basic_b1", {24'h0, rx_log[1]}, 32'hAD);
    check("basic_b2", {24'h0, rx_log[2]}, 32'hBE);
    check("basic_b3", {24'h0, rx_log[3]}, 32'hEF);
    check("basic_left", exp_q.size(), 0);

    // Zero length: done only, no bus activity.
    clear_mon();
    pulse_start(24'h0, 0, 0);
    @(negedge wb_clk_i);
    check("zero_done_next", {31'h0, bus.done_o}, 32'h1);
    wait_cycles(20);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_busy",     {31'h0, busy_seen}, 32'h0);
    check("zero_csb_low",  csb_low, 0);
    check("zero_valid",    {31'h0, valid_seen}, 32'h0);

    // Back-pressure: hold ready low for 200 cycles after the first byte.
    clear_mon();
    bus.data_ready_i = 1'b0;
    pulse_start(24'h0, 3, 1);
    n = 0;
    while (bus.data_valid_o !== 1'b1 && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("bp_first_valid", {31'h0, bus.data_valid_o}, 32'h1);
    sck_hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk_i);
      if (i >= 100 && bus.flash_clk_o !== 1'b0) sck_hi++;
    end
    check("bp_sck_frozen", sck_hi, 0);
    check("bp_sck_low",    {31'h0, bus.flash_clk_o}, 32'h0);
    check("bp_csb_low",    {31'h0, bus.flash_csb_o}, 32'h0);
    check("bp_data_held",  {24'h0, bus.data_o}, 32'hDE);
    check("bp_valid_held", {31'h0, bus.data_valid_o}, 32'h1);
    check("bp_no_done",    done_cnt, 0);
    @(posedge wb_clk_i); #1;
    bus.data_ready_i = 1'b1;
    wait_done(3000, "bp_done");
    wait_cycles(4);
    check("bp_nbytes", rx_log.size(), 3);
    check("bp_b0", {24'h0, rx_log[0]}, 32'hDE);
    check("bp_b1", {24'h0, rx_log[1]}, 32'hAD);
    check("bp_b2", {24'h0, rx_log[2]}, 32'hBE);
    check("bp_left", exp_q.size(), 0);
    check("bp_done_cnt", done_cnt, 1);

    // Second start during ADDR must be ignored.
    clear_mon();
    pulse_start(24'h0, 4, 1);
    wait_cycles(60);
    pulse_start(24'h000100, 2, 0);
    wait_done(3000, "busy_done");
    wait_cycles(4);
    check("busy_hdr",      fl_hdr, {EXP_CMD, 24'h000000});
    check("busy_done_cnt", done_cnt, 1);
    check("busy_nbytes",   rx_log.size(), 4);
    check("busy_b0",       {24'h0, rx_log[0]}, 32'hDE);
    check("busy_left",     exp_q.size(), 0);

    // Asynchronous reset during the second data byte.
    clear_mon();
    pulse_start(24'h0, 4, 1);
    n = 0;
    while (rx_log.size() < 1 && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("rst_mid_first", rx_log.size(), 1);
    wait_cycles(10);
    #3;
    wb_rst_i = 1'b1;
    #1;
    check("rstmid_csb",   {31'h0, bus.flash_csb_o},  32'h1);
    check("rstmid_sck",   {31'h0, bus.flash_clk_o},  32'h0);
    check("rstmid_busy",  {31'h0, bus.busy_o},       32'h0);
    check("rstmid_valid", {31'h0, bus.data_valid_o}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    wait_cycles(20);
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_nbytes",  rx_log.size(), 1);

    // Single-byte read after reset, also pins the CSB-low duration.
    clear_mon();
    pulse_start(24'h000002, 1, 1);
    wait_done(3000, "one_done");
    wait_cycles(4);
    check("one_hdr",      fl_hdr, {EXP_CMD, 24'h000002});
    check("one_csb_low",  csb_low, T_ONE);
    check("one_nbytes",   rx_log.size(), 1);
    check("one_b0",       {24'h0, rx_log[0]}, 32'hBE);
    check("one_done_cnt", done_cnt, 1);
    check("one_left",     exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
